// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the reduced RISC-V datapath
module multicycle_ctrl #(
  parameter int RET_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [31:0]          instr,
  input  logic                 EQ,
  input  logic                 imem_ack,
  input  logic                 dmem_ack,
  output logic                 imem_req,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 PCsrc,
  output logic                 RegWrite,
  output logic                 ResultSrc,
  output logic                 ALUsrc,
  output logic [2:0]           ALUctrl,
  output logic [1:0]           ImmSrc,
  output logic                 halted,
  output logic [2:0]           state,
  output logic [RET_WIDTH-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  state_t cur;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_addi, is_rtype, is_lw, is_sw, is_beq, is_bne, is_branch, is_legal;
  logic [2:0] alu_op;
  logic       retire;
  logic       unused_instr_bits;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  // Register indices and immediates belong to the datapath, not the sequencer.
  assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

  // Classify the held instruction; anything unrecognised is illegal and traps in DECODE.
  always_comb begin
    is_addi   = (opcode == 7'b0010011) && (funct3 == 3'b000);
    is_rtype  = (opcode == 7'b0110011) &&
                (((funct3 == 3'b000) && ((funct7 == 7'b0000000) || (funct7 == 7'b0100000))) ||
                 (funct3 == 3'b111) || (funct3 == 3'b110));
    is_lw     = (opcode == 7'b0000011) && (funct3 == 3'b010);
    is_sw     = (opcode == 7'b0100011) && (funct3 == 3'b010);
    is_beq    = (opcode == 7'b1100011) && (funct3 == 3'b000);
    is_bne    = (opcode == 7'b1100011) && (funct3 == 3'b001);
    is_branch = is_beq || is_bne;
    is_legal  = is_addi || is_rtype || is_lw || is_sw || is_branch;
  end

  // ALU operation for addi / R-type / load-store address generation.
  always_comb begin
    alu_op = ALU_ADD;
    if (is_rtype) begin
      case (funct3)
        3'b000:  alu_op = funct7[5] ? ALU_SUB : ALU_ADD;
        3'b111:  alu_op = ALU_AND;
        default: alu_op = ALU_OR;
      endcase
    end
  end

  // Decode datapath controls from the current state and the held instruction.
  always_comb begin
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    PCsrc     = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 1'b0;
    ALUsrc    = 1'b0;
    ALUctrl   = ALU_ADD;
    ImmSrc    = 2'b00;
    halted    = 1'b0;
    case (cur)
      S_FETCH: begin
        imem_req = run;
        // Gated by reset so an ack arriving during reset cannot latch the IR.
        IRWrite  = rst && run && imem_ack;
      end
      S_EXEC: begin
        if (is_branch) begin
          ALUctrl = ALU_SUB;
          ImmSrc  = 2'b10;
          PCWrite = 1'b1;
          PCsrc   = is_beq ? EQ : ~EQ;
        end else begin
          ALUsrc  = is_addi || is_lw || is_sw;
          ALUctrl = alu_op;
          ImmSrc  = is_sw ? 2'b01 : 2'b00;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_sw;
        ALUsrc   = 1'b1;
        ALUctrl  = ALU_ADD;
        ImmSrc   = is_sw ? 2'b01 : 2'b00;
        PCWrite  = dmem_ack && is_sw;
      end
      S_WB: begin
        RegWrite  = 1'b1;
        PCWrite   = 1'b1;
        ResultSrc = is_lw;
        if (is_addi || is_rtype) begin
          ALUsrc  = is_addi;
          ALUctrl = alu_op;
        end
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign retire = ((cur == S_EXEC) && is_branch) ||
                  ((cur == S_MEM) && dmem_ack && is_sw) ||
                  (cur == S_WB);

  assign state = cur;

  // Sequencer state transitions; undefined encodings trap like an illegal instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur <= S_FETCH;
    end else begin
      case (cur)
        S_FETCH:  if (run && imem_ack) cur <= S_DECODE;
        S_DECODE: cur <= is_legal ? S_EXEC : S_HALT;
        S_EXEC: begin
          if (is_branch)                cur <= S_FETCH;
          else if (is_lw || is_sw)      cur <= S_MEM;
          else if (is_addi || is_rtype) cur <= S_WB;
          else                          cur <= S_HALT;
        end
        S_MEM: begin
          if (dmem_ack) begin
            if (is_sw)      cur <= S_FETCH;
            else if (is_lw) cur <= S_WB;
            else            cur <= S_HALT;
          end
        end
        S_WB:     cur <= S_FETCH;
        S_HALT:   cur <= S_HALT;
        default:  cur <= S_HALT;
      endcase
    end
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instret <= '0;
    end else if (retire) begin
      instret <= instret + {{(RET_WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_LW   = 32'h0000A103;
  localparam logic [31:0] I_BNE  = 32'h00209463;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_SW   = 32'h0020A023;
  localparam logic [31:0] I_ILL  = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic        rst, run, EQ, imem_ack, dmem_ack;
  logic [31:0] instr;
  logic        imem_req, dmem_req, dmem_we, IRWrite, PCWrite, PCsrc, RegWrite, ResultSrc, ALUsrc, halted;
  logic [2:0]  ALUctrl, state;
  logic [1:0]  ImmSrc;
  logic [3:0]  instret;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_ret;

  multicycle_ctrl #(.RET_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .run(run), .instr(instr), .EQ(EQ),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCsrc(PCsrc),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUsrc(ALUsrc),
    .ALUctrl(ALUctrl), .ImmSrc(ImmSrc), .halted(halted),
    .state(state), .instret(instret)
  );

  always #5 clk = ~clk;

  // Observed outputs packed: imem_req dmem_req dmem_we IRWrite PCWrite PCsrc RegWrite ResultSrc ALUsrc ALUctrl[3] ImmSrc[2] halted state[3]
  wire [17:0] outs = {imem_req, dmem_req, dmem_we, IRWrite, PCWrite, PCsrc, RegWrite, ResultSrc,
                      ALUsrc, ALUctrl, ImmSrc, halted, state};

  function automatic logic [17:0] o(input logic ir, dr, we, irw, pcw, pcs, rw, rs, as,
                                    input logic [2:0] ac, input logic [1:0] is,
                                    input logic h, input logic [2:0] st);
    return {ir, dr, we, irw, pcw, pcs, rw, rs, as, ac, is, h, st};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [17:0] e;
    rst = 1'b0; run = 1'b1; instr = 32'h0; EQ = 1'b0; imem_ack = 1'b1; dmem_ack = 1'b0;
    #3;
    e = o(1,0,0,0,0,0,0,0,0,3'd0,2'd0,0,3'd0);
    checks++; if (outs !== e) begin errors++; $display("FAIL reset_outs got=%b exp=%b", outs, e); end
    checks++; if (instret !== 4'd0) begin errors++; $display("FAIL reset_instret got=%0d exp=0", instret); end
    run = 1'b0; #1;
    checks++; if (outs !== 18'd0) begin errors++; $display("FAIL reset_run0 got=%b exp=%b", outs, 18'd0); end
    run = 1'b1;
    tick;
    checks++; if (outs !== e) begin errors++; $display("FAIL reset_hold got=%b exp=%b", outs, e); end
    exp_ret = 4'd0;
  endtask

  task automatic test_addi;
    logic [17:0] seq [4];
    seq[0] = o(1,0,0,1,0,0,0,0,0,3'd0,2'd0,0,3'd0);
    seq[1] = o(0,0,0,0,0,0,0,0,0,3'd0,2'd0,0,3'd1);
    seq[2] = o(0,0,0,0,0,0,0,0,1,3'd0,2'd0,0,3'd2);
    seq[3] = o(0,0,0,0,1,0,1,0,1,3'd0,2'd0,0,3'd4);
    rst = 1'b1; instr = I_ADDI; imem_ack = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (outs !== seq[c]) begin errors++; $display("FAIL addi_c%0d got=%b exp=%b", c, outs, seq[c]); end
      tick;
      imem_ack = 1'b0;
    end
    exp_ret = exp_ret + 4'd1;
    #1;
    checks++; if (state !== 3'd0 || instret !== exp_ret) begin errors++; $display("FAIL addi_end state=%0d instret=%0d exp 0/%0d", state, instret, exp_ret); end
  endtask

  task automatic test_lw_wait;
    logic [17:0] seq [8];
    seq[0] = o(1,0,0,1,0,0,0,0,0,3'd0,2'd0,0,3'd0);
    seq[1] = o(0,0,0,0,0,0,0,0,0,3'd0,2'd0,0,3'd1);
    seq[2] = o(0,0,0,0,0,0,0,0,1,3'd0,2'd0,0,3'd2);
    for (int c = 3; c < 7; c++) seq[c] = o(0,1,0,0,0,0,0,0,1,3'd0,2'd0,0,3'd3);
    seq[7] = o(0,0,0,0,1,0,1,1,0,3'd0,2'd0,0,3'd4);
    instr = I_LW; imem_ack = 1'b1;
    for (int c = 0; c < 8; c++) begin
      dmem_ack = (c == 6);
      #1;
      checks++; if (outs !== seq[c]) begin errors++; $display("FAIL lw_c%0d got=%b exp=%b", c, outs, seq[c]); end
      tick;
      imem_ack = 1'b0;
    end
    dmem_ack = 1'b0;
    exp_ret = exp_ret + 4'd1;
    #1;
    checks++; if (state !== 3'd0 || instret !== exp_ret) begin errors++; $display("FAIL lw_end state=%0d instret=%0d exp 0/%0d", state, instret, exp_ret); end
  endtask

  task automatic test_branch;
    logic [31:0] bi [4];
    logic        beq [4];
    logic        bp  [4];
    logic [17:0] e;
    bi[0] = I_BNE; beq[0] = 1'b0; bp[0] = 1'b1;
    bi[1] = I_BNE; beq[1] = 1'b1; bp[1] = 1'b0;
    bi[2] = I_BEQ; beq[2] = 1'b1; bp[2] = 1'b1;
    bi[3] = I_BEQ; beq[3] = 1'b0; bp[3] = 1'b0;
    for (int v = 0; v < 4; v++) begin
      instr = bi[v]; EQ = beq[v]; imem_ack = 1'b1;
      #1;
      checks++; if (state !== 3'd0 || IRWrite !== 1'b1) begin errors++; $display("FAIL br%0d_fetch state=%0d IRWrite=%b exp 0/1", v, state, IRWrite); end
      tick; imem_ack = 1'b0; #1;
      checks++; if (outs !== o(0,0,0,0,0,0,0,0,0,3'd0,2'd0,0,3'd1)) begin errors++; $display("FAIL br%0d_decode got=%b", v, outs); end
      tick; #1;
      e = o(0,0,0,0,1,bp[v],0,0,0,3'd1,2'd2,0,3'd2);
      checks++; if (outs !== e) begin errors++; $display("FAIL br%0d_exec got=%b exp=%b", v, outs, e); end
      tick;
      exp_ret = exp_ret + 4'd1;
      #1;
      checks++; if (state !== 3'd0 || RegWrite !== 1'b0 || instret !== exp_ret) begin
        errors++; $display("FAIL br%0d_end state=%0d RegWrite=%b instret=%0d exp 0/0/%0d", v, state, RegWrite, instret, exp_ret);
      end
    end
    EQ = 1'b0;
  endtask

  task automatic test_sw_run_drop;
    logic [17:0] seq [6];
    seq[0] = o(1,0,0,1,0,0,0,0,0,3'd0,2'd0,0,3'd0);
    seq[1] = o(0,0,0,0,0,0,0,0,0,3'd0,2'd0,0,3'd1);
    seq[2] = o(0,0,0,0,0,0,0,0,1,3'd0,2'd1,0,3'd2);
    seq[3] = o(0,1,1,0,1,0,0,0,1,3'd0,2'd1,0,3'd3);
    seq[4] = o(0,0,0,0,0,0,0,0,0,3'd0,2'd0,0,3'd0);
    seq[5] = seq[4];
    instr = I_SW; imem_ack = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c == 1) run = 1'b0;
      dmem_ack = (c == 3);
      #1;
      checks++; if (outs !== seq[c]) begin errors++; $display("FAIL sw_c%0d got=%b exp=%b", c, outs, seq[c]); end
      if (c == 3) begin
        checks++; if (instret !== exp_ret) begin errors++; $display("FAIL sw_preretire instret=%0d exp=%0d", instret, exp_ret); end
        exp_ret = exp_ret + 4'd1;
      end
      tick;
    end
    dmem_ack = 1'b0;
    checks++; if (instret !== exp_ret) begin errors++; $display("FAIL sw_retire instret=%0d exp=%0d", instret, exp_ret); end
    run = 1'b1; imem_ack = 1'b0;
  endtask

  task automatic test_illegal;
    logic [17:0] eh;
    int bad;
    eh = o(0,0,0,0,0,0,0,0,0,3'd0,2'd0,1,3'd7);
    instr = I_ILL; imem_ack = 1'b1;
    #1;
    checks++; if (IRWrite !== 1'b1) begin errors++; $display("FAIL ill_fetch IRWrite=%b exp=1", IRWrite); end
    tick; #1;
    checks++; if (outs !== o(0,0,0,0,0,0,0,0,0,3'd0,2'd0,0,3'd1)) begin errors++; $display("FAIL ill_decode got=%b", outs); end
    tick;
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      #1;
      checks++; if (outs !== eh) begin errors++; bad++; if (bad < 4) $display("FAIL ill_halt_c%0d got=%b exp=%b", c, outs, eh); end
      tick;
    end
    #1;
    rst = 1'b0; #1;
    checks++; if (halted !== 1'b0 || state !== 3'd0 || imem_req !== 1'b1 || instret !== 4'd0) begin
      errors++; $display("FAIL ill_reset halted=%b state=%0d imem_req=%b instret=%0d exp 0/0/1/0", halted, state, imem_req, instret);
    end
    exp_ret = 4'd0;
    tick;
  endtask

  task automatic test_reset_mid;
    rst = 1'b1; instr = I_SW; imem_ack = 1'b1; dmem_ack = 1'b0;
    tick; imem_ack = 1'b0;
    tick; tick; #1;
    checks++; if (state !== 3'd3 || dmem_req !== 1'b1 || dmem_we !== 1'b1) begin
      errors++; $display("FAIL mid_mem state=%0d dmem_req=%b dmem_we=%b exp 3/1/1", state, dmem_req, dmem_we);
    end
    imem_ack = 1'b1; dmem_ack = 1'b1;
    rst = 1'b0; #1;
    checks++; if (outs !== o(1,0,0,0,0,0,0,0,0,3'd0,2'd0,0,3'd0) || instret !== 4'd0) begin
      errors++; $display("FAIL mid_reset got=%b instret=%0d exp imem_req only / 0", outs, instret);
    end
    tick;
    checks++; if (state !== 3'd0 || instret !== 4'd0) begin errors++; $display("FAIL mid_hold state=%0d instret=%0d exp 0/0", state, instret); end
    dmem_ack = 1'b0;
  endtask

  task automatic test_back_to_back_wrap;
    logic [2:0] sq [4];
    int bad;
    sq[0] = 3'd0; sq[1] = 3'd1; sq[2] = 3'd2; sq[3] = 3'd4;
    bad = 0;
    rst = 1'b1; run = 1'b1; instr = I_ADDI; imem_ack = 1'b1;
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < 4; k++) begin
        #1;
        checks++; if (state !== sq[k]) begin errors++; bad++; if (bad < 4) $display("FAIL b2b_i%0d_k%0d state=%0d exp=%0d", i, k, state, sq[k]); end
        tick;
      end
      exp_ret = exp_ret + 4'd1;
      checks++; if (instret !== exp_ret) begin errors++; $display("FAIL wrap_i%0d instret=%0d exp=%0d", i, instret, exp_ret); end
    end
    checks++; if (instret !== 4'd0) begin errors++; $display("FAIL wrap_final instret=%0d exp=0", instret); end
    imem_ack = 1'b0;
  endtask

  initial begin
    test_reset;
    test_addi;
    test_lw_wait;
    test_branch;
    test_sw_run_drop;
    test_illegal;
    test_reset_mid;
    test_back_to_back_wrap;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencer for the reduced RISC-V datapath: register file, ALU, sign extender, PC register and instruction/data memories. It replaces the single-cycle combinational control decoder. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB, drives the datapath enables and selects, and handshakes with instruction and data memories that may insert wait states. It also halts on illegal opcodes and counts retired instructions.

## Interface
- `RET_WIDTH`, default 32: width of the retired-instruction counter.
- `clk` input 1: sole clock; all state changes on the rising edge.
- `rst` input 1: reset, asynchronous assert, active-low (0 = reset).
- `run` input 1: when 0, the FSM holds in FETCH without issuing a request.
- `instr` input 32: instruction register contents, valid from DECODE onward.
- `EQ` input 1: ALU zero/equal flag, valid in EXEC.
- `imem_ack` input 1: instruction memory has returned data this cycle.
- `dmem_ack` input 1: data memory access completes this cycle.
- `imem_req` output 1: instruction fetch request.
- `dmem_req` output 1: data access request.
- `dmem_we` output 1: data write (sw); only meaningful while `dmem_req`=1.
- `IRWrite` output 1: latch fetched word into the instruction register.
- `PCWrite` output 1: update the PC register.
- `PCsrc` output 1: 0 = PC+4, 1 = branch target.
- `RegWrite` output 1: register file write enable.
- `ResultSrc` output 1: register write data select; 0 = ALUout, 1 = memory read data.
- `ALUsrc` output 1: 0 = RD2, 1 = ImmOp.
- `ALUctrl` output 3: 000 add, 001 sub, 010 and, 011 or.
- `ImmSrc` output 2: 00 I-type, 01 S-type, 10 B-type.
- `halted` output 1: illegal instruction trapped.
- `state` output 3: FSM state for debug.
- `instret` output RET_WIDTH: count of retired instructions.

## Operation
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7.
- All outputs except `instret` are combinational from the state register and `instr`. Outputs not listed for a state are 0.
- FETCH
  - `imem_req`=run.
  - On `run & imem_ack`: `IRWrite`=1 and go to DECODE. Otherwise stay.
- DECODE: one cycle. Decode `instr[6:0]`:
  - 0010011 addi: funct3 must be 000.
  - 0110011 R-type: funct3 000 with funct7 0000000 (add) or 0100000 (sub); funct3 111 = and; funct3 110 = or.
  - 0000011 lw: funct3 010.
  - 0100011 sw: funct3 010.
  - 1100011 branch: funct3 000 = beq, 001 = bne.
  - Any other combination goes to HALT; otherwise go to EXEC.
- EXEC
  - addi and R-type: set `ALUsrc` and `ALUctrl` per the type; addi uses `ImmSrc`=00. Go to WB.
  - lw/sw: `ALUsrc`=1, `ALUctrl`=add, `ImmSrc`=00 (lw) or 01 (sw). Go to MEM.
  - branch: `ALUctrl`=sub, `ALUsrc`=0, `ImmSrc`=10, `PCWrite`=1.
  - Branch target: `PCsrc`=EQ for beq, `PCsrc`=~EQ for bne.
  - Branch retires here (`instret`+1). Go to FETCH.
- MEM
  - `dmem_req`=1; `dmem_we`=1 for sw. ALU controls are held as in EXEC.
  - On `dmem_ack`:
    - sw: `PCWrite`=1 with `PCsrc`=0, retire, go to FETCH.
    - lw: go to WB.
- WB
  - `RegWrite`=1; `ResultSrc`=1 for lw, otherwise 0. For addi/R-type the EXEC ALU controls are held.
  - `PCWrite`=1 with `PCsrc`=0, retire, go to FETCH.
- HALT: absorbing state. `halted`=1 and all enables are 0. Only reset leaves it.
- `instret` is a registered counter that wraps modulo 2^RET_WIDTH with no saturation.

## Timing
- Reset (`rst`=0), effective immediately and asynchronously:
  - `state`=FETCH, `instret`=0.
  - Every output is 0 except `imem_req`, which follows `run`.
- Reset mid-operation abandons the instruction: no `RegWrite`, `PCWrite` or retire occurs for it.
- Request handshakes: `imem_req`/`dmem_req` rise on state entry and stay high and stable, along with `dmem_we` and the ALU selects, until the ack cycle. They drop the cycle after.
- Acks:
  - An ack in the same cycle as the request rise is accepted, giving zero wait states.
  - An ack while the request is low is ignored.
- `run` falling mid-instruction does not stop it. The instruction completes, and the FSM then idles in FETCH.
- Zero-wait latencies, from FETCH entry to the next FETCH entry:
  - branch: 3 cycles
  - addi / R-type / sw: 4 cycles
  - lw: 5 cycles
- Each memory wait cycle adds 1.
- `PCWrite`, `RegWrite` and `IRWrite` are single-cycle pulses. They are never asserted in the same cycle as each other, except `RegWrite`+`PCWrite` together in WB.

## Test plan
- Reset, then release `rst`=1 with `run`=1 and `imem_ack`=1, instr=0x00500093 (addi x1,x0,5).
  - `state` goes 0,1,2,4,0.
  - `RegWrite` and `PCWrite` are both 1 in cycle 4.
  - `instret`=1 afterward.
- lw 0x0000A103 with `dmem_ack` delayed 3 cycles:
  - `dmem_req` is high for 4 cycles with `dmem_we`=0.
  - Then WB with `ResultSrc`=1.
  - Total 8 cycles.
- bne 0x00209463:
  - With EQ=0: `PCWrite`=1 and `PCsrc`=1 in EXEC.
  - With EQ=1: `PCsrc`=0.
  - In both cases `RegWrite` is never 1.
- sw 0x0020A023 with `dmem_ack` at MEM entry: `dmem_we`=1 for exactly 1 cycle, `ImmSrc`=01, retire in the MEM cycle.
- Illegal opcode 0xFFFFFFFF:
  - `halted`=1 from the cycle after DECODE and stays 1 for 100 cycles.
  - No `imem_req` in that window.
  - Asserting `rst`=0 clears `halted` immediately.
- Reset mid-operation and counter wrap:
  - Assert `rst`=0 in MEM of an sw: `dmem_req`=0 at once, `instret` unchanged at 0.
  - With RET_WIDTH=4, retire 16 addi: `instret` wraps to 0.
